// File: rtl/gp_debounce_pkg.sv
// Shared types and default constants for the general-purpose input debouncer.
package gp_debounce_pkg;

   // Per-bit debounce state: idle on a settled level, or timing a candidate change
   typedef enum logic {
      DB_STABLE   = 1'b0,
      DB_COUNTING = 1'b1
   } db_state_e;

   // 1 kHz sample tick from a 50 MHz system clock
   localparam int unsigned DefaultPrescale    = 50000;
   // 10 ms of agreement before a new level is accepted
   localparam int unsigned DefaultStableTicks = 10;

endpackage

// File: rtl/gp_debounce_bit.sv
// One debounced input: two-flop synchroniser, accept/reject FSM, edge pulses.
module gp_debounce_bit
   import gp_debounce_pkg::*;
#(
   parameter int unsigned StableTicks = DefaultStableTicks,
   parameter logic        ResetValue  = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int unsigned     CntW    = $clog2(StableTicks + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(StableTicks - 1);

   logic            sync_meta;
   logic            sync;
   logic [CntW-1:0] cnt;
   db_state_e       state;

   // Bring the asynchronous pin into the clock domain; only the second stage is used
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_meta <= ResetValue;
         sync      <= ResetValue;
      end else begin
         sync_meta <= raw;
         sync      <= sync_meta;
      end
   end

   // Accept a new level only after StableTicks consecutive ticks of disagreement
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= DB_STABLE;
         cnt   <= '0;
         level <= ResetValue;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         case (state)
            DB_STABLE: begin
               cnt <= '0;
               if (sync != level) begin
                  state <= DB_COUNTING;
                  // A tick coinciding with the first mismatch counts, but never
                  // pushes cnt past its last legal value (StableTicks == 1)
                  if (tick && (LastCnt != '0)) begin
                     cnt <= CntW'(1);
                  end
               end
            end
            DB_COUNTING: begin
               if (sync == level) begin
                  state <= DB_STABLE;
                  cnt   <= '0;
               end else if (tick) begin
                  if (cnt == LastCnt) begin
                     level <= sync;
                     rise  <= sync;
                     fall  <= ~sync;
                     cnt   <= '0;
                     state <= DB_STABLE;
                  end else begin
                     cnt <= cnt + CntW'(1);
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/gp_debounce.sv
// Debouncer for board switches/buttons feeding the demo system's gp_i.
module gp_debounce
   import gp_debounce_pkg::*;
#(
   parameter int unsigned      Width       = 8,
   parameter int unsigned      Prescale    = DefaultPrescale,
   parameter int unsigned      StableTicks = DefaultStableTicks,
   parameter logic [Width-1:0] ResetValue  = '0
) (
   input  logic             clk_sys_i,
   input  logic             rst_sys_ni,
   input  logic [Width-1:0] gp_raw_i,
   output logic [Width-1:0] gp_o,
   output logic [Width-1:0] rise_o,
   output logic [Width-1:0] fall_o
);

   localparam int unsigned    PsW    = (Prescale > 1) ? $clog2(Prescale) : 1;
   localparam logic [PsW-1:0] PsLast = PsW'(Prescale - 1);

   logic [PsW-1:0] ps_cnt;
   logic           tick;

   // Tick is high for the single cycle in which the prescaler sits at its last value
   assign tick = (ps_cnt == PsLast);

   // Shared sample-rate prescaler, counting 0..Prescale-1 and wrapping
   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
         ps_cnt <= '0;
      end else if (tick) begin
         ps_cnt <= '0;
      end else begin
         ps_cnt <= ps_cnt + PsW'(1);
      end
   end

   for (genvar i = 0; i < Width; i++) begin : g_bit
      gp_debounce_bit #(
         .StableTicks (StableTicks),
         .ResetValue  (ResetValue[i])
      ) u_bit (
         .clk   (clk_sys_i),
         .rst_n (rst_sys_ni),
         .tick  (tick),
         .raw   (gp_raw_i[i]),
         .level (gp_o[i]),
         .rise  (rise_o[i]),
         .fall  (fall_o[i])
      );
   end

endmodule

// File: tb/tb_gp_debounce.sv
// Scoreboard bench: one debouncer at Prescale=4/StableTicks=3, one at 1/1.
module tb_gp_debounce;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] raw1, gp1, rise1, fall1;
   logic [3:0] raw2, gp2, rise2, fall2;

   int cyc = 0;
   int rel = 0;
   int checks = 0;
   int errors = 0;
   logic [3:0] prev_gp [2];

   typedef struct {
      int         dut;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] gp;
      int         start;
      int         lo;
      int         hi;
   } exp_t;

   exp_t sb [$];

   gp_debounce #(
      .Width(4), .Prescale(4), .StableTicks(3), .ResetValue(4'b0101)
   ) dut1 (
      .clk_sys_i(clk), .rst_sys_ni(rst_n), .gp_raw_i(raw1),
      .gp_o(gp1), .rise_o(rise1), .fall_o(fall1)
   );

   gp_debounce #(
      .Width(4), .Prescale(1), .StableTicks(1), .ResetValue(4'b0000)
   ) dut2 (
      .clk_sys_i(clk), .rst_sys_ni(rst_n), .gp_raw_i(raw2),
      .gp_o(gp2), .rise_o(rise2), .fall_o(fall2)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Edge counters: total edges, and edges since the last reset release
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!rst_n) rel = 0;
      else        rel = rel + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Compare one DUT's outputs against the reset value or the scoreboard
   task automatic monitorDut(input int d, input logic [3:0] g, input logic [3:0] r,
                             input logic [3:0] f, input logic [3:0] rv);
      int   idx;
      int   lat;
      exp_t e;
      if (!rst_n) begin
         check($sformatf("reset_pulse%0d", d), {24'h0, r, f}, 32'h0);
         check($sformatf("reset_gp%0d", d), {28'h0, g}, {28'h0, rv});
      end else if (r != 4'h0 || f != 4'h0 || g != prev_gp[d]) begin
         idx = -1;
         for (int j = 0; j < sb.size(); j++) begin
            if (idx < 0 && sb[j].dut == d) idx = j;
         end
         if (idx < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event%0d: gp %b rise %b fall %b, none expected (cycle %0d)",
                     d, g, r, f, cyc);
         end else begin
            e = sb[idx];
            sb.delete(idx);
            check($sformatf("rise%0d", d), {28'h0, r}, {28'h0, e.rise});
            check($sformatf("fall%0d", d), {28'h0, f}, {28'h0, e.fall});
            check($sformatf("gp%0d", d), {28'h0, g}, {28'h0, e.gp});
            lat = cyc - e.start;
            checks++;
            if (lat < e.lo || lat > e.hi) begin
               errors++;
               $display("[TB] FAIL latency%0d: got %0d cycles expected %0d..%0d", d, lat, e.lo, e.hi);
            end
         end
      end
      prev_gp[d] = g;
   endtask

   // Monitor: sample both DUTs just after each active edge
   always @(posedge clk) begin
      #1;
      monitorDut(0, gp1, rise1, fall1, 4'b0101);
      monitorDut(1, gp2, rise2, fall2, 4'b0000);
   end

   // Drive a new raw vector and record the response it must produce
   task automatic applyStimulus(input int d, input logic [3:0] new_raw, input logic [3:0] er,
                                input logic [3:0] ef, input logic [3:0] eg,
                                input int lo, input int hi);
      exp_t e;
      if (d == 0) raw1 = new_raw;
      else        raw2 = new_raw;
      e.dut = d; e.rise = er; e.fall = ef; e.gp = eg;
      e.start = cyc; e.lo = lo; e.hi = hi;
      sb.push_back(e);
   endtask

   // Any entry still queued has timed out; then confirm the settled level
   task automatic checkOutput(input int d, input logic [3:0] eg);
      int pending;
      pending = 0;
      for (int j = sb.size() - 1; j >= 0; j--) begin
         if (sb[j].dut == d) begin
            pending++;
            sb.delete(j);
         end
      end
      check($sformatf("pending%0d", d), pending, 0);
      check($sformatf("settled_gp%0d", d), {28'h0, (d == 0) ? gp1 : gp2}, {28'h0, eg});
   endtask

   // Stop on the negedge right after a prescaler tick edge, so the phase is known
   task automatic alignTick();
      do @(negedge clk); while (rel % 4 != 0);
   endtask

   // Directed sequence
   initial begin
      rst_n = 1'b0;
      raw1  = 4'b0101;
      raw2  = 4'b0000;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      checkOutput(0, 4'b0101);

      // Clean fall then clean rise on bit0, first mismatch away from a tick
      alignTick();
      applyStimulus(0, 4'b0100, 4'b0000, 4'b0001, 4'b0100, 12, 15);
      repeat (20) @(negedge clk);
      checkOutput(0, 4'b0100);
      alignTick();
      applyStimulus(0, 4'b0101, 4'b0001, 4'b0000, 4'b0101, 12, 15);
      repeat (20) @(negedge clk);
      checkOutput(0, 4'b0101);

      // Bit1 bouncing every 5 cycles must be rejected, then a held level accepted
      for (int i = 0; i < 12; i++) begin
         raw1[1] = ~raw1[1];
         repeat (5) @(negedge clk);
      end
      checkOutput(0, 4'b0101);
      applyStimulus(0, 4'b0111, 4'b0010, 4'b0000, 4'b0111, 11, 15);
      repeat (20) @(negedge clk);
      checkOutput(0, 4'b0111);

      // Raise bit3, then drop bits 3 and 2 together
      applyStimulus(0, 4'b1111, 4'b1000, 4'b0000, 4'b1111, 11, 15);
      repeat (20) @(negedge clk);
      checkOutput(0, 4'b1111);
      applyStimulus(0, 4'b0011, 4'b0000, 4'b1100, 4'b0011, 11, 15);
      repeat (20) @(negedge clk);
      checkOutput(0, 4'b0011);

      // Reset after two ticks of counting on bit0; the count must start over
      alignTick();
      raw1 = 4'b0010;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 4'b0010, 4'b0010, 4'b0101, 4'b0010, 11, 15);
      repeat (20) @(negedge clk);
      checkOutput(0, 4'b0010);

      // Fastest configuration: exactly 4 cycles from raw edge to gp change
      applyStimulus(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4, 4);
      repeat (10) @(negedge clk);
      checkOutput(1, 4'b0001);
      applyStimulus(1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4, 4);
      repeat (10) @(negedge clk);
      checkOutput(1, 4'b0000);

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
